keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces it, and reports one held key as a 5-bit code plus a level `keypad_pressed`. It produces the `keypad_pressed`/`key` pair consumed by the hero-select/game-control logic: selection keys 4/6 and action keys 8/0/9. It also emits a one-cycle `key_strobe` per accepted press for other consumers.

## Interface

**Parameters**
- `SCAN_DIV`, default 4: clock cycles each column stays driven. Must be ≥ 3.
- `DEBOUNCE`, default 3: consecutive identical scan frames required to accept a press or a release. Must be ≥ 1.

**Ports**
- `clk` input 1: single system clock.
- `rst` input 1: synchronous, active-high reset.
- `row_in` input 4: keypad rows, active-low, pulled up externally, asynchronous to `clk`.
- `col_out` output 4: column drive, active-low one-hot.
- `keypad_pressed` output 1: high while a debounced key is held.
- `key` output 5: code of the last accepted key. Holds its value after release.
- `key_strobe` output 1: one-cycle pulse when a press is accepted.

## Operation

**Key codes.** Row r (0 = top) and column c (0 = left) map as follows:
- Row 0: 1, 2, 3, 10(A)
- Row 1: 4, 5, 6, 11(B)
- Row 2: 7, 8, 9, 12(C)
- Row 3: 14(*), 0, 15(#), 13(D)
- Code 5'd31 means "none". It is the value only after reset.

**Input path and scanning**
- `row_in` passes through a 2-flop synchronizer before any use.
- A column counter steps c = 0→1→2→3→0. `col_out` drives bit c low and all other bits high.
- A frame is 4 slots of `SCAN_DIV` cycles each.
- Synchronized rows are sampled on the last cycle of each slot.
- A low row bit r in slot c marks key (r,c) as down.

**Frame result**, evaluated on the last cycle of slot 3:
- NONE: no key down.
- ONE(k): exactly one key down, with code k.
- MULTI: two or more keys down. MULTI is treated as NONE for all transitions (ghost rejection).

**FSM.** State, `cand`, and `cnt` update on the evaluation cycle only.
- IDLE:
  - ONE(k) → `cand` = k, `cnt` = 1. If `DEBOUNCE` = 1, accept immediately; otherwise go to PRESS_DB.
- PRESS_DB:
  - ONE(`cand`) → `cnt`++. When `cnt` reaches `DEBOUNCE`, accept.
  - ONE(j≠`cand`) → `cand` = j, `cnt` = 1 (restart).
  - NONE → IDLE.
- Accept:
  - `key` ← `cand`, `keypad_pressed` ← 1, `key_strobe` ← 1 for one cycle.
  - Go to HELD.
- HELD:
  - ONE(`key`) → stay.
  - Anything else → `cnt` = 1. If `DEBOUNCE` = 1, release immediately; otherwise go to REL_DB.
- REL_DB:
  - ONE(`key`) → HELD. This is a bounce: no strobe, `keypad_pressed` stays 1.
  - Anything else → `cnt`++. When `cnt` reaches `DEBOUNCE`, release.
- Release:
  - `keypad_pressed` ← 0, `key` unchanged.
  - Go to IDLE.

**Other rules**
- A different key pressed while one is held is not reported until the held key is released and the new key is debounced from IDLE.
- `cnt` is wide enough to hold `DEBOUNCE` and never wraps.

## Timing

**Reset values.** Reset is synchronous and takes effect at the next edge:
- `col_out` = 4'b1110, column counter = 0, slot counter = 0.
- `keypad_pressed` = 0, `key_strobe` = 0, `key` = 5'd31.
- Synchronizer flops = 4'b1111, state IDLE, `cand` = 0, `cnt` = 0.
- Reset mid-press or mid-hold drops `keypad_pressed` and `key` immediately. A key still held is re-detected from IDLE with a new strobe.

**Cycle-level timing**
- Frame length is 4·`SCAN_DIV` cycles. `col_out` changes only at slot boundaries.
- A row change must precede a column's sample cycle by ≥ 2 cycles (synchronizer latency) to count in that frame.
- Outputs are registered. `keypad_pressed` and `key` change, and `key_strobe` pulses, on the cycle after the evaluation cycle.
- Press latency: `DEBOUNCE` complete frames containing the key, plus 1 cycle. Release latency is the same count.
- `key_strobe` is never high on two consecutive cycles and never high during reset.

## Test plan

All scenarios use `SCAN_DIV` = 4 and `DEBOUNCE` = 3, so a frame is 16 cycles.

1. **Reset and scan.** Assert `rst` 2 cycles, rows idle at 4'b1111 → outputs at the reset values above. `col_out` then steps 1110, 1101, 1011, 0111, each for 4 cycles, repeating. `keypad_pressed` stays 0.
2. **Clean press and release.** Hold key (1,0) for 8 frames, then release → `keypad_pressed` rises and `key` = 4 one cycle after the end of the 3rd frame, with exactly one `key_strobe`. `keypad_pressed` falls one cycle after the 3rd empty frame, and `key` stays 4.
3. **Press bounce.** Key (1,2) down 2 frames, up 1 frame, down 5 frames → no strobe before the 3rd consecutive down frame. Then `key` = 6 with a single strobe.
4. **Release bounce.** While `key` = 8 is held, go up 1 frame then down again → `keypad_pressed` stays 1 throughout with no second strobe. A later 3-frame release clears it.
5. **Multi-key rejection.** Keys 8 and 9 pressed together for 5 frames, then 9 released → nothing reported during the overlap. `key` = 8 is accepted 3 frames after the release of 9.
6. **Reset mid-hold.** Key 0 held and accepted, `rst` pulsed for 1 cycle with the key still down → `keypad_pressed` = 0 and `key` = 31 on the next cycle. `key` = 0 is re-accepted with a new strobe 3 frames later.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if : keypad matrix lines plus the debounced key report
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       keypad_pressed;
  logic [4:0] key;
  logic       key_strobe;

  modport master (
    input  row_in,
    output col_out,
    output keypad_pressed,
    output key,
    output key_strobe
  );

  modport slave (
    output row_in,
    input  col_out,
    input  keypad_pressed,
    input  key,
    input  key_strobe
  );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner : 4x4 active-low keypad scan, ghost rejection and debounce
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam int              CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       KEY_NONE = 5'd31;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col;
  logic [3:0]       col_drive;
  logic [15:0]      down;

  logic             slot_end;
  logic             frame_end;
  logic [15:0]      frame_down;
  logic [4:0]       hit_cnt;
  logic [3:0]       hit_idx;
  logic             one_hit;
  logic [4:0]       hit_code;

  state_t           state;
  logic [4:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             pressed;
  logic [4:0]       key_q;
  logic             strobe;

  function automatic logic [4:0] key_code(input logic [3:0] idx);
    logic [4:0] code;
    case (idx)
      4'd0:    code = 5'd1;
      4'd1:    code = 5'd2;
      4'd2:    code = 5'd3;
      4'd3:    code = 5'd10;
      4'd4:    code = 5'd4;
      4'd5:    code = 5'd5;
      4'd6:    code = 5'd6;
      4'd7:    code = 5'd11;
      4'd8:    code = 5'd7;
      4'd9:    code = 5'd8;
      4'd10:   code = 5'd9;
      4'd11:   code = 5'd12;
      4'd12:   code = 5'd14;
      4'd13:   code = 5'd0;
      4'd14:   code = 5'd15;
      default: code = 5'd13;
    endcase
    return code;
  endfunction

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (col == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 4'b1111;
      sync2     <= 4'b1111;
      div_cnt   <= '0;
      col       <= 2'd0;
      col_drive <= 4'b1110;
    end else begin
      sync1 <= kp.row_in;
      sync2 <= sync1;
      if (slot_end) begin
        div_cnt   <= '0;
        col       <= col + 2'd1;
        col_drive <= ~(4'b0001 << (col + 2'd1));
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  // down[r*4+c] holds the most recent sample of key (r,c)
  always_ff @(posedge clk) begin
    if (rst) begin
      down <= '0;
    end else if (slot_end) begin
      down[{2'd0, col}] <= ~sync2[0];
      down[{2'd1, col}] <= ~sync2[1];
      down[{2'd2, col}] <= ~sync2[2];
      down[{2'd3, col}] <= ~sync2[3];
    end
  end

  // Column 3 is still being sampled on the evaluation cycle, so take it live
  always_comb begin
    frame_down     = down;
    frame_down[3]  = ~sync2[0];
    frame_down[7]  = ~sync2[1];
    frame_down[11] = ~sync2[2];
    frame_down[15] = ~sync2[3];
  end

  always_comb begin
    hit_cnt = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_down[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign one_hit  = (hit_cnt == 5'd1);
  assign hit_code = key_code(hit_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= 5'd0;
      cnt     <= '0;
      pressed <= 1'b0;
      key_q   <= KEY_NONE;
      strobe  <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (one_hit) begin
              cand <= hit_code;
              cnt  <= CNT_ONE;
              if (DEBOUNCE == 1) begin
                key_q   <= hit_code;
                pressed <= 1'b1;
                strobe  <= 1'b1;
                state   <= HELD;
              end else begin
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (one_hit && hit_code == cand) begin
              if (cnt + CNT_ONE == CNT_LAST) begin
                key_q   <= cand;
                pressed <= 1'b1;
                strobe  <= 1'b1;
                state   <= HELD;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else if (one_hit) begin
              cand <= hit_code;
              cnt  <= CNT_ONE;
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (!(one_hit && hit_code == key_q)) begin
              cnt <= CNT_ONE;
              if (DEBOUNCE == 1) begin
                pressed <= 1'b0;
                state   <= IDLE;
              end else begin
                state <= REL_DB;
              end
            end
          end
          default: begin
            // REL_DB: the held key reappearing is a bounce, not a new press
            if (one_hit && hit_code == key_q) begin
              state <= HELD;
            end else if (cnt + CNT_ONE == CNT_LAST) begin
              pressed <= 1'b0;
              state   <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

  assign kp.col_out        = col_drive;
  assign kp.keypad_pressed = pressed;
  assign kp.key            = key_q;
  assign kp.key_strobe     = strobe;

endmodule

`default_nettype wire
